// File: rtl/uart_stepper_pkg.sv
// Shared constants, state types and frame-geometry helpers for the UART
// stepper controller.
package uart_stepper_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int FLAG_DIR   = 0;
  localparam int FLAG_ABORT = 1;

  localparam int IDX_SYNC  = 0;
  localparam int IDX_FLAGS = 1;
  localparam int IDX_HALF  = 2;

  function automatic int field_bytes(input int cnt_w);
    return cnt_w / 8;
  endfunction

  function automatic int idx_count(input int cnt_w);
    return IDX_HALF + field_bytes(cnt_w);
  endfunction

  function automatic int idx_csum(input int cnt_w);
    return IDX_HALF + 2 * field_bytes(cnt_w);
  endfunction

  function automatic int frame_len(input int cnt_w);
    return idx_csum(cnt_w) + 1;
  endfunction

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {A_SYNC, A_COLLECT, A_CHECK} asm_state_e;
  typedef enum logic {E_IDLE, E_RUN} eng_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with input synchroniser, byte-valid and stop-error pulses.
module uart_rx_byte
  import uart_stepper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       stop_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  rx_state_e       st;
  logic [1:0]      sync;
  logic            rx_d;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  // Start is a falling edge, so a line still low after a bad stop bit
  // cannot retrigger a phantom byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= RX_IDLE;
      sync     <= 2'b11;
      rx_d     <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      data     <= '0;
      valid    <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      sync     <= {sync[0], rx};
      rx_d     <= sync[1];
      valid    <= 1'b0;
      stop_err <= 1'b0;
      case (st)
        RX_IDLE: if (!sync[1] && rx_d) begin
          st  <= RX_START;
          cnt <= '0;
        end
        RX_START: if (cnt == CW'(HALF)) begin
          cnt     <= '0;
          bit_idx <= '0;
          st      <= sync[1] ? RX_IDLE : RX_DATA;
        end else cnt <= cnt + CW'(1);
        RX_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt   <= '0;
          shreg <= {sync[1], shreg[7:1]};
          if (bit_idx == 3'd7) st <= RX_STOP;
          else bit_idx <= bit_idx + 3'd1;
        end else cnt <= cnt + CW'(1);
        RX_STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt <= '0;
          st  <= RX_IDLE;
          if (sync[1]) begin
            valid <= 1'b1;
            data  <= shreg;
          end else stop_err <= 1'b1;
        end else cnt <= cnt + CW'(1);
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_stepper_ctrl.sv
// Framed-command stepper controller: UART byte receiver, checksummed frame
// assembler and STEP/DIR pulse engine.
module uart_stepper_ctrl
  import uart_stepper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int PRESCALE     = 1,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic             i_Rx_Serial,
  output logic             o_Step,
  output logic             o_Dir_A,
  output logic             o_Dir_B,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Frame_Err,
  output logic [CNT_W-1:0] o_Steps_Done
);

  localparam int FL       = frame_len(CNT_W);
  localparam int NB       = field_bytes(CNT_W);
  localparam int IDX_CNT  = idx_count(CNT_W);
  localparam int IDX_CSUM = idx_csum(CNT_W);
  localparam int IDX_W    = $clog2(FL);
  localparam int TO_LIM   = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIM + 1);
  localparam int PH_W     = CNT_W + $clog2(PRESCALE);
  localparam logic [PH_W-1:0] PRE = PH_W'(PRESCALE);

  logic [7:0] rx_data;
  logic       rx_valid, rx_stop_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (i_Clock),
    .rst_n    (i_Rst_n),
    .rx       (i_Rx_Serial),
    .data     (rx_data),
    .valid    (rx_valid),
    .stop_err (rx_stop_err)
  );

  // ---------------- frame assembler ----------------
  asm_state_e          ast;
  logic [IDX_W-1:0]    idx;
  logic [TO_W-1:0]     tcnt;
  logic [FL-1:1][7:0]  fbuf;
  logic                frame_err;

  logic [CNT_W-1:0] half, count;
  logic [7:0]       xsum;
  logic             cmd_abort, cmd_dir, frame_ok, ld_move, ld_abort, in_check;

  always_comb begin
    half  = '0;
    count = '0;
    xsum  = '0;
    for (int i = 0; i < NB; i++) begin
      half  = CNT_W'({half,  fbuf[IDX_HALF + i]});
      count = CNT_W'({count, fbuf[IDX_CNT + i]});
    end
    for (int i = 1; i < IDX_CSUM; i++) xsum = xsum ^ fbuf[i];
  end

  assign cmd_abort = fbuf[IDX_FLAGS][FLAG_ABORT];
  assign cmd_dir   = fbuf[IDX_FLAGS][FLAG_DIR];
  assign frame_ok  = (xsum == fbuf[IDX_CSUM]) &&
                     (cmd_abort || (half != '0 && count != '0));
  assign in_check  = (ast == A_CHECK);
  assign ld_move   = in_check && frame_ok && !cmd_abort;
  assign ld_abort  = in_check && frame_ok && cmd_abort;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ast       <= A_SYNC;
      idx       <= '0;
      tcnt      <= '0;
      fbuf      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_stop_err) begin
        ast       <= A_SYNC;
        frame_err <= 1'b1;
      end else begin
        case (ast)
          A_SYNC: if (rx_valid && rx_data == SYNC_BYTE) begin
            ast  <= A_COLLECT;
            idx  <= IDX_W'(IDX_FLAGS);
            tcnt <= '0;
          end
          A_COLLECT: if (rx_valid) begin
            fbuf[idx] <= rx_data;
            tcnt      <= '0;
            if (idx == IDX_W'(IDX_CSUM)) ast <= A_CHECK;
            else idx <= idx + IDX_W'(1);
          end else if (tcnt == TO_W'(TO_LIM)) begin
            ast       <= A_SYNC;
            frame_err <= 1'b1;
          end else tcnt <= tcnt + TO_W'(1);
          A_CHECK: begin
            ast <= A_SYNC;
            if (!frame_ok) frame_err <= 1'b1;
          end
          default: ast <= A_SYNC;
        endcase
      end
    end
  end

  // ---------------- step engine ----------------
  eng_state_e        est;
  logic              step, busy, done, dir_a, dir_b;
  logic [CNT_W-1:0]  steps, target;
  logic [PH_W-1:0]   ph_cnt, ph_lim;

  // A fresh load outranks the terminal step of the running move.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      est    <= E_IDLE;
      step   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dir_a  <= 1'b0;
      dir_b  <= 1'b0;
      steps  <= '0;
      target <= '0;
      ph_cnt <= '0;
      ph_lim <= '0;
    end else begin
      done <= 1'b0;
      if (ld_move) begin
        est    <= E_RUN;
        busy   <= 1'b1;
        step   <= 1'b1;
        steps  <= '0;
        target <= count;
        ph_cnt <= '0;
        ph_lim <= PH_W'(half) * PRE;
        dir_a  <= cmd_dir;
        dir_b  <= !cmd_dir;
      end else if (ld_abort) begin
        est  <= E_IDLE;
        busy <= 1'b0;
        step <= 1'b0;
      end else if (est == E_RUN) begin
        if (ph_cnt == ph_lim - PH_W'(1)) begin
          ph_cnt <= '0;
          if (step) step <= 1'b0;
          else begin
            steps <= steps + CNT_W'(1);
            if (steps + CNT_W'(1) == target) begin
              done <= 1'b1;
              busy <= 1'b0;
              est  <= E_IDLE;
            end else step <= 1'b1;
          end
        end else ph_cnt <= ph_cnt + PH_W'(1);
      end
    end
  end

  assign o_Step       = step;
  assign o_Dir_A      = dir_a;
  assign o_Dir_B      = dir_b;
  assign o_Busy       = busy;
  assign o_Done       = done;
  assign o_Frame_Err  = frame_err;
  assign o_Steps_Done = steps;

endmodule

// File: tb/tb_uart_stepper_ctrl.sv
// Bench for uart_stepper_ctrl: event-list behavioural model checked every cycle,
// plus literal checks for the directed scenarios.
module tb_uart_stepper_ctrl;

  localparam int CPB    = 8;
  localparam int PRE    = 1;
  localparam int CW     = 16;
  localparam int TOB    = 20;
  localparam int HALF   = (CPB - 1) / 2;
  // negedge that drives a last start bit -> first cycle the load is visible
  localparam int LAT    = 6 + HALF + 9 * CPB;
  localparam int TO_LIM = TOB * CPB;

  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic step, dir_a, dir_b, busy, done, ferr;
  logic [CW-1:0] steps_done;

  uart_stepper_ctrl #(.CLKS_PER_BIT(CPB), .PRESCALE(PRE), .CNT_W(CW), .TIMEOUT_BITS(TOB)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx),
    .o_Step(step), .o_Dir_A(dir_a), .o_Dir_B(dir_b), .o_Busy(busy),
    .o_Done(done), .o_Frame_Err(ferr), .o_Steps_Done(steps_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  // Model: list of effects (0 move, 1 abort, 2 reset) with the cycle they become visible.
  int ev_c[$], ev_t[$], ev_h[$], ev_n[$];
  bit ev_d[$];
  bit err_at[int];

  function automatic void push_ev(input int c, input int t, input int h, input int n, input bit d);
    ev_c.push_back(c); ev_t.push_back(t); ev_h.push_back(h); ev_n.push_back(n); ev_d.push_back(d);
  endfunction

  function automatic int last_ev(input int c);
    int j = -1;
    foreach (ev_c[i]) if (ev_c[i] <= c) j = i;
    return j;
  endfunction

  function automatic int sd_at(input int c0);
    int c = c0, j, per, k;
    while (1) begin
      j = last_ev(c);
      if (j < 0 || ev_t[j] == 2) return 0;
      if (ev_t[j] == 0) begin
        per = 2 * ev_h[j] * PRE;
        k   = c - ev_c[j];
        return (k / per < ev_n[j]) ? k / per : ev_n[j];
      end
      c = ev_c[j] - 1;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // per-cycle compare against the model
  int mj, mk, mper;
  logic m_step, m_busy, m_done, m_a, m_b, m_err;
  logic [CW-1:0] m_sd;
  always @(negedge clk) if (cyc >= 1) begin
    m_step = 0; m_busy = 0; m_done = 0; m_a = 0; m_b = 0;
    mj   = last_ev(cyc);
    m_sd = CW'(sd_at(cyc));
    for (int i = mj; i >= 0; i--) begin
      if (ev_t[i] == 2) break;
      if (ev_t[i] == 0) begin m_a = ev_d[i]; m_b = !ev_d[i]; break; end
    end
    if (mj >= 0 && ev_t[mj] == 0) begin
      mper = 2 * ev_h[mj] * PRE;
      mk   = cyc - ev_c[mj];
      if (mk < ev_n[mj] * mper) begin
        m_busy = 1;
        m_step = (mk % mper) < ev_h[mj] * PRE;
      end else if (mk == ev_n[mj] * mper) m_done = 1;
    end
    m_err = err_at.exists(cyc);
    tests++;
    if ({step, dir_a, dir_b, busy, done, ferr, steps_done} !==
        {m_step, m_a, m_b, m_busy, m_done, m_err, m_sd}) begin
      fails++;
      $display("FAIL model @cycle %0d: got step=%b a=%b b=%b busy=%b done=%b err=%b sd=%0d, expected step=%b a=%b b=%b busy=%b done=%b err=%b sd=%0d",
               cyc, step, dir_a, dir_b, busy, done, ferr, steps_done,
               m_step, m_a, m_b, m_busy, m_done, m_err, m_sd);
    end
  end

  task automatic send_byte(input logic [7:0] v, input bit stop_ok, output int c0);
    @(negedge clk);
    c0 = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] fl, input logic [15:0] h, input logic [15:0] n,
                            input logic [7:0] cs, input int gap, output int ld);
    logic [7:0] b [7];
    int c0;
    b = '{8'hA5, fl, h[15:8], h[7:0], n[15:8], n[7:0], cs};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      send_byte(b[i], 1'b1, c0);
    end
    ld = c0 + LAT;
    if ((fl ^ h[15:8] ^ h[7:0] ^ n[15:8] ^ n[7:0]) != cs || (!fl[1] && (h == 0 || n == 0)))
      err_at[ld] = 1'b1;
    else
      push_ev(ld, fl[1] ? 1 : 0, int'(h), int'(n), fl[0]);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [7:0] xs(input logic [7:0] fl, input logic [15:0] h, input logic [15:0] n);
    return fl ^ h[15:8] ^ h[7:0] ^ n[15:8] ^ n[7:0];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int ld, la, c0;
    logic [7:0] fl, cs;
    logic [15:0] h, n;
    push_ev(0, 2, 1, 1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_outputs", {step, dir_a, dir_b, busy, done, ferr, steps_done}, 32'h0);

    // basic move: 4 steps of 3/3, dir 0
    send_frame(8'h00, 16'd3, 16'd4, 8'h07, 0, ld);
    wait_until(ld);
    chk("load_busy", busy, 1);
    chk("load_step", step, 1);
    chk("load_dir", {dir_a, dir_b}, 2'b01);
    wait_until(ld + 3);
    chk("first_low", step, 0);
    wait_until(ld + 23);
    chk("busy_before_done", busy, 1);
    wait_until(ld + 24);
    chk("done_pulse", {done, busy}, 2'b10);
    wait_until(ld + 25);
    chk("steps_done_4", {done, steps_done}, {1'b0, 16'd4});

    // bad checksum
    send_frame(8'h00, 16'd3, 16'd4, 8'h06, 0, ld);
    wait_until(ld);
    chk("csum_err", {ferr, busy}, 2'b10);
    wait_until(ld + 1);
    chk("csum_err_one_cycle", ferr, 0);

    // garbage then valid frame, dir 1
    send_byte(8'h11, 1'b1, c0);
    send_byte(8'h22, 1'b1, c0);
    send_frame(8'h01, 16'd2, 16'd3, xs(8'h01, 16'd2, 16'd3), 3, ld);
    wait_until(ld);
    chk("garbage_then_move", {busy, dir_a, dir_b}, 3'b110);

    // inter-byte timeout after byte3
    repeat (50) @(negedge clk);
    send_byte(8'hA5, 1'b1, c0);
    send_byte(8'h00, 1'b1, c0);
    send_byte(8'h00, 1'b1, c0);
    send_byte(8'h05, 1'b1, c0);
    err_at[c0 + LAT + TO_LIM] = 1'b1;
    repeat (21 * CPB) @(negedge clk);
    send_frame(8'h00, 16'd1, 16'd2, xs(8'h00, 16'd1, 16'd2), 0, ld);
    wait_until(ld);
    chk("after_timeout_move", busy, 1);

    // abort at step 2 of a 10-step move
    repeat (20) @(negedge clk);
    send_frame(8'h00, 16'd100, 16'd10, xs(8'h00, 16'd100, 16'd10), 0, ld);
    send_frame(8'h02, 16'd0, 16'd0, 8'h02, 0, la);
    wait_until(la);
    chk("abort_state", {step, busy, done, steps_done}, {3'b000, 16'd2});
    wait_until(ld + 2005);
    chk("abort_held", {busy, steps_done}, {1'b0, 16'd2});

    // stop bit low on byte2, then reset mid-move
    send_byte(8'hA5, 1'b1, c0);
    send_byte(8'h00, 1'b1, c0);
    send_byte(8'h12, 1'b0, c0);
    err_at[c0 + LAT - 1] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h00, 16'd50, 16'd10, xs(8'h00, 16'd50, 16'd10), 1, ld);
    wait_until(ld + 130);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", {step, dir_a, dir_b, busy, done, ferr, steps_done}, 32'h0);
    push_ev(cyc + 1, 2, 1, 1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // randomized frames, some overlapping running moves
    for (int r = 0; r < 14; r++) begin
      fl = {6'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom)};
      h  = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
      n  = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
      cs = xs(fl, h, n);
      if ($urandom_range(0, 5) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
      send_frame(fl, h, n, cs, $urandom_range(0, 20), ld);
      repeat ($urandom_range(0, 80)) @(negedge clk);
    end
    repeat (1100) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_stepper_ctrl.md
# uart_stepper_ctrl

Framed-command stepper motor controller: an 8N1 UART receiver feeds a checksummed 7-byte command assembler, which loads a step-pulse generator with direction, half-period and step count. It replaces the fixed 4-byte receive / RPM-divider step generator. It adds frame sync, an inter-byte timeout, a checksum, abort, a programmable step count, busy/done status and error reporting, with no hardware divider. The block sits between the host serial line and the motor driver's STEP/DIR pins.

## Interface
- CLKS_PER_BIT, 104, clocks per UART bit (clock freq / baud); ≥ 8
- PRESCALE, 1, clock multiplier applied to the half-period field; ≥ 1
- CNT_W, 16, width of half-period and step-count fields (8 or 16 only)
- TIMEOUT_BITS, 20, idle bit-times between bytes before the assembler resynchronises
- i_Clock  in  1  single system clock, rising edge
- i_Rst_n  in  1  asynchronous active-low reset
- i_Rx_Serial  in  1  UART line, idle high, asynchronous (2-flop synchronised inside)
- o_Step  out  1  step pulse train to driver
- o_Dir_A  out  1  direction pin 1
- o_Dir_B  out  1  direction pin 2
- o_Busy  out  1  high while a move is in progress
- o_Done  out  1  one-cycle pulse when a move completes its count
- o_Frame_Err  out  1  one-cycle pulse on any rejected byte or frame
- o_Steps_Done  out  CNT_W  steps completed in the current or last move

## Operation
- Byte receiver: waits for a low start bit, re-checks it at (CLKS_PER_BIT-1)/2, then samples 8 data bits LSB-first at the bit centres and the stop bit at its centre.
- A low stop bit discards the byte, pulses o_Frame_Err and returns the assembler to SYNC.
- Frame layout (CNT_W=16):
  - byte0: sync 0xA5
  - byte1: flags (bit0 dir, bit1 abort)
  - bytes2-3: half-period, MSB first
  - bytes4-5: step count, MSB first
  - byte6: XOR of bytes 1..5
  - With CNT_W=8, fields are one byte each and the frame is 5 bytes.
- Assembler states:
  - SYNC: non-0xA5 bytes are dropped silently.
  - COLLECT: stores bytes by index.
  - CHECK: validates the frame.
  - More than TIMEOUT_BITS×CLKS_PER_BIT idle clocks in COLLECT: go to SYNC, pulse o_Frame_Err.
- CHECK rejects (o_Frame_Err pulse, no effect on motion) on:
  - checksum mismatch
  - half-period = 0 or step count = 0 when abort = 0
- Abort frame (abort = 1, checksum valid; period and count ignored): o_Step → 0 immediately, o_Busy → 0, no o_Done; o_Steps_Done holds its value.
- Motion frame, accepted in IDLE or RUN:
  - o_Steps_Done clears, counters load, o_Dir_A/o_Dir_B update.
  - dir = 0 → A=0, B=1; dir = 1 → A=1, B=0. Both hold after the move ends.
  - A motion frame accepted while RUN restarts the move with the new parameters.
- Step engine states IDLE / RUN:
  - o_Step is high for half-period×PRESCALE clocks, then low for the same.
  - o_Steps_Done increments at the end of each low phase.
  - When o_Steps_Done reaches the count: o_Done pulse, o_Busy falls, state → IDLE.
- Arithmetic: the phase counter is CNT_W + clog2(PRESCALE) bits wide, so it never wraps before terminal count. The step counter compares for equality only.

## Timing
- Reset values: o_Step 0, o_Dir_A 0, o_Dir_B 0, o_Busy 0, o_Done 0, o_Frame_Err 0, o_Steps_Done 0. Assembler in SYNC, engine in IDLE.
- The final byte is complete on its stop-bit centre sample (cycle T).
  - CHECK occupies T+1.
  - Load occurs at T+2: o_Busy = 1, o_Step = 1, direction pins valid.
- o_Done and the o_Busy fall share the same cycle: the cycle after the last low phase ends.
- o_Frame_Err is asserted for exactly 1 cycle per error event.
- Reset mid-frame or mid-move: all state returns to reset values at once. The partial frame is lost.
- Accept cycle coinciding with the terminal step: the new frame wins, no o_Done.

## Structure
- Package uart_stepper_pkg holds:
  - SYNC_BYTE, flag bit positions, frame byte indices
  - assembler and engine state enums
  - frame length function of CNT_W
- One sub-module, uart_rx_byte: 8N1 receiver with a byte-valid pulse and a stop-error pulse, reusable elsewhere.
- Assembler, checksum and step engine live in uart_stepper_ctrl.

## Test plan
- Frame A5 00 0003 0004 07, PRESCALE=1 → o_Busy at T+2; 4 steps of 3 high / 3 low; o_Done 24 clocks after load; o_Dir_A=0, o_Dir_B=1; o_Steps_Done=4.
- Same frame with byte6=06 → one o_Frame_Err pulse; o_Busy stays 0.
- Garbage 11 22, then valid frame → the garbage is dropped silently and the move runs.
- Stall of 21 bit-times after byte3 → o_Frame_Err, then a fresh frame is accepted.
- Abort frame A5 02 0000 0000 02 sent at step 2 of a 10-step move → o_Step=0, o_Busy=0, no o_Done, o_Steps_Done=2.
- Stop bit forced low on byte2, plus i_Rst_n asserted mid-move → error pulse, then all outputs zero asynchronously.
